mmio_port_unit: RTL and testbench

- Memory-mapped I/O unit in the MEM stage, in parallel with data_memory.
- Decodes the EX/MEM ALU-result address and claims a 32-byte window.
- Drives the processor's PortOut register.
- Synchronizes PortIn and records input changes.
- Provides a free-running cycle counter.
- Returns read data combinationally from registered state, so the MEM/WB register captures it in the same cycle as RAM data.

---
 rtl/mmio_port_unit_pkg.sv | 31 +++
 rtl/mmio_port_unit_if.sv | 36 +++
 rtl/mmio_port_unit_input_sync_detect.sv | 43 ++++
 rtl/mmio_port_unit.sv | 129 ++++++++++++
 tb/tb_mmio_port_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_port_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_port_unit_pkg
// Description : Shared constants for the MEM-stage memory-mapped I/O unit:
//               word offsets inside the 32-byte window and the bit positions
//               of the CTRL and STATUS registers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_port_unit_pkg;

  // Word offsets (address[4:2]) inside the window
  localparam logic [2:0] OFF_OUT    = 3'd0;
  localparam logic [2:0] OFF_IN     = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_COUNT  = 3'd4;

  // CTRL bit indices
  localparam int CTRL_CLR_FLAG = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_CNT_EN   = 2;
  localparam int CTRL_CNT_ZERO = 3;

  // STATUS bit indices
  localparam int STAT_FLAG   = 0;
  localparam int STAT_IE     = 1;
  localparam int STAT_CNT_EN = 2;

endpackage : mmio_port_unit_pkg
`default_nettype wire

// File: rtl/mmio_port_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_port_unit_if
// Description : Bus bundle between the MEM stage and the I/O unit.
//               master : pipeline side (drives address/enables/store data and
//                        the external PortIn pins)
//               slave  : the I/O unit (returns hit, read data, port outputs)
// Ports       : address, read_enable, write_enable, in_data, PortIn,
//               mmio_hit, out_data, PortOut, port_strobe, irq
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_port_unit_if #(
  parameter int IN_WIDTH = 8
);
  logic [31:0]         address;
  logic                read_enable;
  logic                write_enable;
  logic [31:0]         in_data;
  logic [IN_WIDTH-1:0] PortIn;
  logic                mmio_hit;
  logic [31:0]         out_data;
  logic [31:0]         PortOut;
  logic                port_strobe;
  logic                irq;

  modport master (
    output address, read_enable, write_enable, in_data, PortIn,
    input  mmio_hit, out_data, PortOut, port_strobe, irq
  );

  modport slave (
    input  address, read_enable, write_enable, in_data, PortIn,
    output mmio_hit, out_data, PortOut, port_strobe, irq
  );
endinterface : mmio_port_unit_if
`default_nettype wire

// File: rtl/mmio_port_unit_input_sync_detect.sv
`default_nettype none
// ============================================================================
// Module      : mmio_port_unit_input_sync_detect
// Description : Two-flop synchronizer for the asynchronous PortIn pins plus a
//               one-cycle-delayed copy used to detect input changes.
// Ports       : clk, reset (async, active-high)
//               port_in_i [IN_WIDTH] - raw external pins
//               sync_o    [IN_WIDTH] - synchronized value (second stage)
//               change_o             - high while sync_o differs from the
//                                      previous cycle's sync_o
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_port_unit_input_sync_detect #(
  parameter int IN_WIDTH = 8
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [IN_WIDTH-1:0] port_in_i,
  output logic      [IN_WIDTH-1:0] sync_o,
  output logic                     change_o
);

  logic [IN_WIDTH-1:0] sync1_q;
  logic [IN_WIDTH-1:0] sync2_q;
  logic [IN_WIDTH-1:0] prev_in_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_in_q <= '0;
    end else begin
      sync1_q   <= port_in_i;
      sync2_q   <= sync1_q;
      prev_in_q <= sync2_q;
    end
  end

  assign sync_o   = sync2_q;
  assign change_o = (sync2_q != prev_in_q);

endmodule : mmio_port_unit_input_sync_detect
`default_nettype wire

// File: rtl/mmio_port_unit.sv
`default_nettype none
// ============================================================================
// Module      : mmio_port_unit
// Description : MEM-stage memory-mapped I/O unit. Claims a 32-byte window at
//               BASE_ADDR and provides OUT, IN, STATUS, CTRL and COUNT
//               registers. Read data is a combinational mux of registered
//               state so it lines up with RAM read data.
// Ports       : clk, reset (async, active-high)
//               bus (slave) : address, read_enable, write_enable, in_data,
//                             PortIn -> mmio_hit, out_data, PortOut,
//                             port_strobe, irq
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_port_unit
  import mmio_port_unit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_FF00,  // must be 32-byte aligned
  parameter int          IN_WIDTH  = 8               // must match bus IN_WIDTH, < 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mmio_port_unit_if.slave bus
);

  logic [31:0]         port_out_q,  port_out_d;
  logic                strobe_q,    strobe_d;
  logic                flag_q,      flag_d;
  logic                ie_q,        ie_d;
  logic                cnt_en_q,    cnt_en_d;
  logic [31:0]         cnt_q,       cnt_d;

  logic [IN_WIDTH-1:0] w_sync;
  logic                w_change;
  logic [2:0]          w_offset;
  logic                w_wr;
  logic                w_rd;
  logic [31:0]         w_in_ext;
  logic [31:0]         w_rdata;
  logic [1:0]          w_unused_addr_lsb;

  mmio_port_unit_input_sync_detect #(
    .IN_WIDTH (IN_WIDTH)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .port_in_i (bus.PortIn),
    .sync_o    (w_sync),
    .change_o  (w_change)
  );

  // Byte lane bits are irrelevant: all registers are full words
  assign w_unused_addr_lsb = bus.address[1:0];
  assign w_offset          = bus.address[4:2];
  assign bus.mmio_hit      = (bus.address[31:5] == BASE_ADDR[31:5]);
  assign w_wr              = bus.mmio_hit & bus.write_enable;
  assign w_rd              = bus.mmio_hit & bus.read_enable;

  always_comb begin
    port_out_d = port_out_q;
    strobe_d   = 1'b0;
    flag_d     = flag_q | w_change;
    ie_d       = ie_q;
    cnt_en_d   = cnt_en_q;
    cnt_d      = cnt_en_q ? cnt_q + 32'd1 : cnt_q;
    if (w_wr) begin
      case (w_offset)
        OFF_OUT: begin
          port_out_d = bus.in_data;
          strobe_d   = 1'b1;
        end
        OFF_CTRL: begin
          // A change arriving on the clearing edge must not be lost
          if (bus.in_data[CTRL_CLR_FLAG]) flag_d = w_change;
          ie_d     = bus.in_data[CTRL_IE];
          cnt_en_d = bus.in_data[CTRL_CNT_EN];
          if (bus.in_data[CTRL_CNT_ZERO]) cnt_d = 32'd0;
        end
        OFF_COUNT: cnt_d = bus.in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q <= 32'd0;
      strobe_q   <= 1'b0;
      flag_q     <= 1'b0;
      ie_q       <= 1'b0;
      cnt_en_q   <= 1'b1;
      cnt_q      <= 32'd0;
    end else begin
      port_out_q <= port_out_d;
      strobe_q   <= strobe_d;
      flag_q     <= flag_d;
      ie_q       <= ie_d;
      cnt_en_q   <= cnt_en_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    w_in_ext                 = 32'd0;
    w_in_ext[IN_WIDTH-1:0]   = w_sync;
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_offset)
      OFF_OUT:    w_rdata = port_out_q;
      OFF_IN:     w_rdata = w_in_ext;
      OFF_STATUS: begin
        w_rdata[STAT_FLAG]   = flag_q;
        w_rdata[STAT_IE]     = ie_q;
        w_rdata[STAT_CNT_EN] = cnt_en_q;
      end
      OFF_COUNT:  w_rdata = cnt_q;
      default:    w_rdata = 32'd0;
    endcase
  end

  // counter_en resets to 1, so STATUS would be nonzero during reset without this gate
  assign bus.out_data    = (w_rd && !reset) ? w_rdata : 32'd0;
  assign bus.PortOut     = port_out_q;
  assign bus.port_strobe = strobe_q;
  assign bus.irq         = flag_q & ie_q;

endmodule : mmio_port_unit
`default_nettype wire

// File: tb/tb_mmio_port_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_port_unit
// Description : Directed self-checking bench for mmio_port_unit. Inputs are
//               driven on the falling edge; registered effects are observed
//               on the falling edge after the rising edge that causes them.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_port_unit;

  localparam logic [31:0] A_OUT    = 32'h1001_FF00;
  localparam logic [31:0] A_IN     = 32'h1001_FF04;
  localparam logic [31:0] A_STATUS = 32'h1001_FF08;
  localparam logic [31:0] A_CTRL   = 32'h1001_FF0C;
  localparam logic [31:0] A_COUNT  = 32'h1001_FF10;
  localparam logic [31:0] A_UNMAP  = 32'h1001_FF18;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mmio_port_unit_if #(.IN_WIDTH(8)) bus ();

  mmio_port_unit #(
    .BASE_ADDR (32'h1001_FF00),
    .IN_WIDTH  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write issued during the low phase, captured at the next rising edge;
  // returns at the following falling edge with write_enable dropped.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.address      = a;
    bus.in_data      = d;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b0;
    @(negedge clk);
    bus.write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.address     = a;
    bus.read_enable = 1'b1;
    #1;
    chk(tag, bus.out_data, exp);
    bus.read_enable = 1'b0;
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    bus.address      = A_COUNT;
    bus.read_enable  = 1'b1;
    bus.write_enable = 1'b0;
    bus.in_data      = 32'd0;
    bus.PortIn       = 8'h00;

    // ---------------- reset state ----------------
    #2;
    chk("rst_portout", bus.PortOut, 32'd0);
    chk("rst_strobe", {31'd0, bus.port_strobe}, 32'd0);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    chk("rst_rdata_zero", bus.out_data, 32'd0);
    chk("rst_hit", {31'd0, bus.mmio_hit}, 32'd1);

    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd_chk("count_after_5", A_COUNT, 32'd5);
    chk("idle_irq", {31'd0, bus.irq}, 32'd0);
    rd_chk("status_reset", A_STATUS, 32'h4);

    // ---------------- OUT write / strobe ----------------
    do_write(A_OUT, 32'hDEAD_BEEF);
    chk("out_value", bus.PortOut, 32'hDEAD_BEEF);
    chk("strobe_hi", {31'd0, bus.port_strobe}, 32'd1);
    @(negedge clk);
    chk("strobe_lo", {31'd0, bus.port_strobe}, 32'd0);
    rd_chk("out_readback", A_OUT, 32'hDEAD_BEEF);

    bus.address      = 32'h1001_0000;
    bus.in_data      = 32'h1111_2222;
    bus.write_enable = 1'b1;
    #1;
    chk("miss_hit", {31'd0, bus.mmio_hit}, 32'd0);
    @(negedge clk);
    bus.write_enable = 1'b0;
    chk("miss_out_keep", bus.PortOut, 32'hDEAD_BEEF);
    chk("miss_no_strobe", {31'd0, bus.port_strobe}, 32'd0);

    // back-to-back identical writes keep the strobe high
    do_write(A_OUT, 32'hDEAD_BEEF);
    chk("b2b_strobe1", {31'd0, bus.port_strobe}, 32'd1);
    do_write(A_OUT, 32'hDEAD_BEEF);
    chk("b2b_strobe2", {31'd0, bus.port_strobe}, 32'd1);
    @(negedge clk);
    chk("b2b_strobe_end", {31'd0, bus.port_strobe}, 32'd0);

    // ---------------- input change detection ----------------
    bus.PortIn = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    rd_chk("status_2edges", A_STATUS, 32'h4);
    rd_chk("in_value", A_IN, 32'h0000_005A);
    @(negedge clk);
    rd_chk("status_3edges", A_STATUS, 32'h5);
    chk("irq_masked", {31'd0, bus.irq}, 32'd0);

    do_write(A_CTRL, 32'h6);  // enable irq, keep counter running
    chk("irq_set", {31'd0, bus.irq}, 32'd1);
    rd_chk("status_ie", A_STATUS, 32'h7);
    do_write(A_CTRL, 32'h7);  // clear flag
    chk("irq_cleared", {31'd0, bus.irq}, 32'd0);
    rd_chk("status_clr", A_STATUS, 32'h6);

    // change detected on the same edge as the clear: set wins
    bus.PortIn = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    do_write(A_CTRL, 32'h7);
    rd_chk("clr_vs_set", A_STATUS, 32'h7);
    chk("clr_vs_set_irq", {31'd0, bus.irq}, 32'd1);
    @(negedge clk);
    rd_chk("flag_sticky", A_STATUS, 32'h7);

    // ---------------- counter ----------------
    do_write(A_COUNT, 32'hFFFF_FFFE);
    rd_chk("cnt_load", A_COUNT, 32'hFFFF_FFFE);
    @(negedge clk);
    rd_chk("cnt_ffff", A_COUNT, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_chk("cnt_wrap", A_COUNT, 32'h0000_0000);

    do_write(A_CTRL, 32'h8);  // zero + disable, ie cleared
    rd_chk("cnt_zero_frozen", A_COUNT, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rd_chk("cnt_still_frozen", A_COUNT, 32'd0);
    rd_chk("status_frozen", A_STATUS, 32'h1);

    do_write(A_CTRL, 32'hC);
    rd_chk("cnt_zero_run", A_COUNT, 32'd0);
    @(negedge clk);
    rd_chk("cnt_run1", A_COUNT, 32'd1);
    @(negedge clk);
    rd_chk("cnt_run2", A_COUNT, 32'd2);

    // ---------------- unmapped / write-only reads ----------------
    rd_chk("unmapped_rd", A_UNMAP, 32'd0);
    rd_chk("ctrl_rd", A_CTRL, 32'd0);
    bus.address = A_UNMAP;
    #1;
    chk("unmapped_hit", {31'd0, bus.mmio_hit}, 32'd1);
    do_write(A_UNMAP, 32'h5555_5555);
    chk("unmapped_wr_ign", bus.PortOut, 32'hDEAD_BEEF);
    do_write(A_IN, 32'h5555_5555);
    rd_chk("ro_in_wr_ign", A_IN, 32'h0000_00A5);

    // ---------------- simultaneous read + write ----------------
    bus.address      = A_OUT;
    bus.in_data      = 32'h1234_5678;
    bus.read_enable  = 1'b1;
    bus.write_enable = 1'b1;
    #1;
    chk("rw_old_value", bus.out_data, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.write_enable = 1'b0;
    #1;
    chk("rw_new_value", bus.out_data, 32'h1234_5678);
    bus.read_enable = 1'b0;

    // ---------------- reset mid-operation ----------------
    do_write(A_OUT, 32'hCAFE_F00D);
    chk("pre_rst_strobe", {31'd0, bus.port_strobe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out", bus.PortOut, 32'd0);
    chk("mid_rst_strobe", {31'd0, bus.port_strobe}, 32'd0);
    chk("mid_rst_irq", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    bus.address      = A_OUT;
    bus.in_data      = 32'h0BAD_0BAD;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_blocks_wr", bus.PortOut, 32'd0);
    chk("rst_blocks_strobe", {31'd0, bus.port_strobe}, 32'd0);
    @(negedge clk);
    bus.write_enable = 1'b0;
    reset = 1'b0;
    rd_chk("rst_sync_clear", A_IN, 32'd0);
    rd_chk("rst_status", A_STATUS, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mmio_port_unit
`default_nettype wire
